lpc_record_serializer: RTL and testbench
========================================

// Module: lpc_record_serializer
// PURPOSE
//  Downstream of the lpc decoder. Captures each decoded LPC cycle (cyctype/dir, addr, data, size)
//  on its one-cycle enable pulse and queues it in a small record FIFO.
//  Emits each record as a byte stream with valid/ready handshake, for a UART/USB logging back end.
//  Flags and counts records lost to FIFO overflow so the host can detect gaps.
// PARAMETERS
//  DEPTH      4   record FIFO depth in entries; power of two, >= 2
//  CNT_W      8   width of saturating drop counter
// PORTS
//  lpc_clock        in   1    sole clock; all logic on posedge
//  lpc_reset        in   1    asynchronous, active-low reset
//  in_cyctype_dir   in   4    decoder out_cyctype_dir
//  in_addr          in   32   decoder out_addr
//  in_data          in   32   decoder out_data; byte0 = first LPC data byte
//  in_data_size     in   3    decoder out_data_size, in bytes
//  in_strobe        in   1    decoder out_clock_enable; one-cycle pulse = record valid
//  out_byte         out  8    stream byte
//  out_valid        out  1    out_byte valid
//  out_ready        in   1    sink accepts out_byte when out_valid & out_ready at posedge
//  out_drop_count   out  CNT_W  records dropped since reset; saturates at all-ones
//  out_fifo_level   out  $clog2(DEPTH)+1  entries held in FIFO (excludes record in serializer)
// BEHAVIOUR
//  Reset (async, lpc_reset=0): out_valid=0, out_byte=0, FIFO empty, drop count 0, overflow flag 0,
//   FSM=IDLE. Record in flight is lost. No output glitch on release; first push on first edge after.
//  Push: at posedge with in_strobe=1: if FIFO not full (state before the edge) write
//   {ct,addr,data,size}. Otherwise drop, set sticky ovf flag, increment drop count (saturating).
//   Full is evaluated before the edge. A strobe while full is dropped even if a pop occurs on the same edge.
//  Record format, bytes in order:
//   B0 = {ct[3:0], ovf, size[2:0]}; B1..B4 = addr[31:24],[23:16],[15:8],[7:0];
//   then N data bytes, data[7:0] first; N = min(size,4) (size 0 -> no data bytes; 5..7 -> 4).
//   Record length = 5+N bytes.
//  FSM: IDLE -> HDR -> ADDR (4 beats, 2-bit idx) -> DATA (N beats) -> IDLE or HDR.
//   IDLE: if FIFO non-empty: pop head into the record register. Same edge: out_byte=B0, out_valid=1, go to HDR.
//   Each beat advances only on out_valid & out_ready. out_byte/out_valid are registered and stable while stalled.
//   Last beat accepted with FIFO non-empty: pop and load the next B0 on the same edge.
//    No idle bubble between back-to-back records.
//   Last beat accepted with FIFO empty: out_valid=0, go to IDLE.
//  Overflow flag: sampled into B0 when a header is loaded, then cleared.
//   If a drop happens on the header-load edge, the flag stays set (set wins) and goes to the following record.
//  Latency: strobe sampled at edge k into an empty, idle block -> B0 valid after edge k+1.
//  Pointers: log2(DEPTH)+1 bits; full = MSBs differ and rest equal; wrap is natural modulo.
//  Simultaneous push+pop when not full: both occur; level unchanged.
// STRUCTURE
//  Shared include lpc_defs.vh holds:
//   cyctype/dir codes (e.g. CT_MEM_WR=4'b0110, CT_IO_RD=4'b0000);
//   record field widths (REC_W=71);
//   header bit positions; REC_MAX_BYTES=9.
//  Sub-module lpc_rec_fifo: sync FIFO, REC_W x DEPTH, push/pop/full/empty/level, async active-low reset.
//  Top holds the serializer FSM, beat counter, ovf flag and drop counter.
// TESTING
//  1 Mem write ct=0110 addr=12347fe5 data=6c size=1, out_ready=1:
//    bytes 61 12 34 7F E5 6C; valid from edge k+1 for 6 cycles, then 0.
//  2 Same record, out_ready high 1 cycle in 3: identical byte sequence.
//    out_byte and out_valid stable in every stalled cycle.
//  3 IO read ct=0000 addr=0000002e data=AABBCCDD size=4:
//    04 00 00 00 2E DD CC BB AA.
//  4 DEPTH=4, out_ready=0, 7 strobes on consecutive edges: drop_count=2, fifo_level=4.
//    Then set ready=1: records 1..5 emitted; B0 of record 2 has bit3=1; others have bit3=0.
//  5 Two records pushed back-to-back, ready=1: 12 bytes with out_valid continuously high, no gap.
//  6 Assert lpc_reset after 3 bytes of a record: out_valid=0 without a clock edge.
//    After release: level=0, drop_count=0, no output until the next strobe.

Source files
------------

// File: rtl/lpc_record_serializer_pkg.sv
// Shared definitions for the LPC record serializer: cycle codes, record layout, byte helpers.
package lpc_record_serializer_pkg;

    localparam logic [3:0] CT_IO_RD  = 4'b0000;
    localparam logic [3:0] CT_IO_WR  = 4'b0010;
    localparam logic [3:0] CT_MEM_RD = 4'b0100;
    localparam logic [3:0] CT_MEM_WR = 4'b0110;

    localparam int unsigned CT_W          = 4;
    localparam int unsigned ADDR_W        = 32;
    localparam int unsigned DATA_W        = 32;
    localparam int unsigned SIZE_W        = 3;
    localparam int unsigned REC_W         = CT_W + ADDR_W + DATA_W + SIZE_W;
    localparam int unsigned REC_MAX_BYTES = 9;
    localparam int unsigned HDR_OVF_BIT   = 3;
    localparam int unsigned HDR_CT_LSB    = 4;

    typedef struct packed {
        logic [CT_W-1:0]   ct;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [SIZE_W-1:0] size;
    } lpc_rec_t;

    // Data beats carried by a record: sizes above four are clipped to one word.
    function automatic logic [2:0] rec_data_bytes(input logic [2:0] size);
        return (size > 3'd4) ? 3'd4 : size;
    endfunction

    // Header byte {ct, ovf, size}.
    function automatic logic [7:0] rec_hdr(input lpc_rec_t r, input logic ovf);
        return {r.ct, ovf, r.size};
    endfunction

    // Byte i of a 32-bit word, byte 0 = bits [7:0].
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] i);
        return w[{i, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/lpc_record_serializer_fifo.sv
// Synchronous record FIFO with extra-MSB pointers; head entry is presented combinationally.
module lpc_rec_fifo
    import lpc_record_serializer_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [REC_W-1:0]       wr_data,
    input  logic                   pop,
    output logic [REC_W-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [REC_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign full    = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign level   = wr_ptr_q - rd_ptr_q;
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/lpc_record_serializer.sv
// Queues decoded LPC cycles and streams each as header, address and data bytes over valid/ready.
module lpc_record_serializer
    import lpc_record_serializer_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                   lpc_clock,
    input  logic                   lpc_reset,
    input  logic [3:0]             in_cyctype_dir,
    input  logic [31:0]            in_addr,
    input  logic [31:0]            in_data,
    input  logic [2:0]             in_data_size,
    input  logic                   in_strobe,
    output logic [7:0]             out_byte,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CNT_W-1:0]       out_drop_count,
    output logic [$clog2(DEPTH):0] out_fifo_level
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_ADDR = 2'd2;
    localparam logic [1:0] ST_DATA = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      data_q, data_d;
    logic [2:0]       n_q, n_d;
    logic [7:0]       byte_q, byte_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    lpc_rec_t         wr_rec_c;
    lpc_rec_t         head_c;
    logic             fifo_full, fifo_empty;
    logic             pop_c, load_c, last_c, accept_c, drop_c;

    assign wr_rec_c = '{ct: in_cyctype_dir, addr: in_addr, data: in_data, size: in_data_size};
    assign drop_c   = in_strobe & fifo_full;
    assign accept_c = valid_q & out_ready;

    lpc_rec_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (lpc_clock),
        .rst_n   (lpc_reset),
        .push    (in_strobe),
        .wr_data (wr_rec_c),
        .pop     (pop_c),
        .rd_data (head_c),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (out_fifo_level)
    );

    // Beat sequencing, header load from the FIFO head, overflow flag and drop counter.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        data_d  = data_q;
        n_d     = n_q;
        byte_d  = byte_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        drop_d  = drop_q;
        pop_c   = 1'b0;
        load_c  = 1'b0;
        last_c  = 1'b0;

        case (state_q)
            ST_IDLE: load_c = ~fifo_empty;
            ST_HDR: begin
                if (accept_c) begin
                    state_d = ST_ADDR;
                    idx_d   = 2'd0;
                    byte_d  = word_byte(addr_q, 2'd3);
                end
            end
            ST_ADDR: begin
                if (accept_c) begin
                    if (idx_q != 2'd3) begin
                        idx_d  = idx_q + 2'd1;
                        byte_d = word_byte(addr_q, 2'd2 - idx_q);
                    end else if (n_q != 3'd0) begin
                        state_d = ST_DATA;
                        idx_d   = 2'd0;
                        byte_d  = word_byte(data_q, 2'd0);
                    end else begin
                        last_c = 1'b1;
                    end
                end
            end
            default: begin
                if (accept_c) begin
                    if (({1'b0, idx_q} + 3'd1) < n_q) begin
                        idx_d  = idx_q + 2'd1;
                        byte_d = word_byte(data_q, idx_q + 2'd1);
                    end else begin
                        last_c = 1'b1;
                    end
                end
            end
        endcase

        // Back-to-back records chain without an idle bubble.
        if (last_c) begin
            if (!fifo_empty) begin
                load_c = 1'b1;
            end else begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        end

        if (load_c) begin
            pop_c   = 1'b1;
            addr_d  = head_c.addr;
            data_d  = head_c.data;
            n_d     = rec_data_bytes(head_c.size);
            byte_d  = rec_hdr(head_c, ovf_q);
            valid_d = 1'b1;
            state_d = ST_HDR;
            ovf_d   = 1'b0;
        end

        // A drop on the header-load edge keeps the flag for the next record.
        if (drop_c) begin
            ovf_d = 1'b1;
            if (drop_q != '1) begin
                drop_d = drop_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            n_q     <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            n_q     <= n_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    assign out_byte       = byte_q;
    assign out_valid      = valid_q;
    assign out_drop_count = drop_q;

endmodule

// File: tb/tb_lpc_record_serializer.sv
// Bench for lpc_record_serializer: byte-queue reference model, per-cycle compare, directed pins.
module tb_lpc_record_serializer;
    import lpc_record_serializer_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 8;
    localparam int          SAT   = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        lpc_reset;
    logic [3:0]  in_cyctype_dir;
    logic [31:0] in_addr;
    logic [31:0] in_data;
    logic [2:0]  in_data_size;
    logic        in_strobe;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready;
    logic [CNT_W-1:0]       out_drop_count;
    logic [$clog2(DEPTH):0] out_fifo_level;

    always #5 clk = ~clk;

    lpc_record_serializer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .lpc_clock      (clk),
        .lpc_reset      (lpc_reset),
        .in_cyctype_dir (in_cyctype_dir),
        .in_addr        (in_addr),
        .in_data        (in_data),
        .in_data_size   (in_data_size),
        .in_strobe      (in_strobe),
        .out_byte       (out_byte),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_drop_count (out_drop_count),
        .out_fifo_level (out_fifo_level)
    );

    // Reference model: pending records, bytes still to send for the record in flight.
    lpc_rec_t   m_fifo[$];
    logic [7:0] m_cur[$];
    logic       m_ovf;
    int         m_drop;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic       chk_en   = 1'b0;
    logic [7:0] acc_log[$];
    lpc_rec_t   idle_r;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic void model_load(input lpc_rec_t r);
        int nd;
        m_cur.push_back({r.ct, m_ovf, r.size});
        for (int i = 3; i >= 0; i--) m_cur.push_back(8'((r.addr >> (8 * i)) & 32'hff));
        nd = (r.size > 3'd4) ? 4 : int'(r.size);
        for (int j = 0; j < nd; j++) m_cur.push_back(8'((r.data >> (8 * j)) & 32'hff));
    endfunction

    function automatic void model_edge(input bit strobe, input lpc_rec_t r, input bit ready);
        bit full_before;
        lpc_rec_t h;
        full_before = (m_fifo.size() == DEPTH);
        if (m_cur.size() > 0 && ready) void'(m_cur.pop_front());
        if (m_cur.size() == 0 && m_fifo.size() > 0) begin
            h = m_fifo.pop_front();
            model_load(h);
            m_ovf = 1'b0;
        end
        if (strobe) begin
            if (full_before) begin
                m_ovf = 1'b1;
                if (m_drop < SAT) m_drop++;
            end else begin
                m_fifo.push_back(r);
            end
        end
    endfunction

    function automatic void model_reset();
        m_fifo.delete();
        m_cur.delete();
        m_ovf  = 1'b0;
        m_drop = 0;
    endfunction

    // Single per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid", 32'(out_valid), 32'(m_cur.size() > 0));
            if (m_cur.size() > 0) chk("byte", 32'(out_byte), 32'(m_cur[0]));
            chk("level", 32'(out_fifo_level), 32'(m_fifo.size()));
            chk("drops", 32'(out_drop_count), 32'(m_drop));
        end
    end

    task automatic step(input bit strobe, input lpc_rec_t r, input bit ready);
        in_strobe      = strobe;
        in_cyctype_dir = r.ct;
        in_addr        = r.addr;
        in_data        = r.data;
        in_data_size   = r.size;
        out_ready      = ready;
        if (out_valid && ready) acc_log.push_back(out_byte);
        @(posedge clk);
        model_edge(strobe, r, ready);
        #1;
    endtask

    task automatic drain();
        int k = 0;
        while ((m_cur.size() > 0 || m_fifo.size() > 0) && k < 200) begin
            step(1'b0, idle_r, 1'b1);
            k++;
        end
        chk("drain_timeout", 32'(k < 200), 32'd1);
        step(1'b0, idle_r, 1'b1);
    endtask

    function automatic lpc_rec_t mk(input logic [3:0] ct, input logic [31:0] a,
                                    input logic [31:0] d, input logic [2:0] s);
        lpc_rec_t r;
        r.ct = ct; r.addr = a; r.data = d; r.size = s;
        return r;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        lpc_rec_t   r1, r3, rr;
        logic [7:0] exp1[6];
        logic [7:0] exp3[9];
        int         gap;
        int         k;
        bit         rdy_bias;

        exp1 = '{8'h61, 8'h12, 8'h34, 8'h7F, 8'hE5, 8'h6C};
        exp3 = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h2E, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
        idle_r = '0;
        r1 = mk(CT_MEM_WR, 32'h12347fe5, 32'h0000006c, 3'd1);
        r3 = mk(CT_IO_RD, 32'h0000002e, 32'hAABBCCDD, 3'd4);

        lpc_reset = 1'b0;
        in_strobe = 1'b0; in_cyctype_dir = '0; in_addr = '0; in_data = '0; in_data_size = '0;
        out_ready = 1'b0;
        model_reset();
        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_byte", 32'(out_byte), 32'd0);
        chk("rst_level", 32'(out_fifo_level), 32'd0);
        chk("rst_drops", 32'(out_drop_count), 32'd0);
        @(posedge clk); #1;
        lpc_reset = 1'b1;
        chk_en    = 1'b1;
        step(1'b0, idle_r, 1'b1);

        // Single memory write, sink always ready; B0 visible one edge after the strobe edge.
        acc_log.delete();
        step(1'b1, r1, 1'b1);
        chk("t1_latency_k", 32'(out_valid), 32'd0);
        step(1'b0, idle_r, 1'b1);
        chk("t1_latency_k1", 32'(out_valid), 32'd1);
        chk("t1_first_b0", 32'(out_byte), 32'h61);
        drain();
        chk("t1_len", 32'(acc_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < acc_log.size(); i++) chk("t1_byte", 32'(acc_log[i]), 32'(exp1[i]));

        // Same record, sink ready one cycle in three.
        acc_log.delete();
        step(1'b1, r1, 1'b0);
        for (int i = 0; i < 30; i++) step(1'b0, idle_r, (i % 3) == 2);
        drain();
        chk("t2_len", 32'(acc_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < acc_log.size(); i++) chk("t2_byte", 32'(acc_log[i]), 32'(exp1[i]));

        // IO read with four data bytes, little-endian data order.
        acc_log.delete();
        step(1'b1, r3, 1'b1);
        drain();
        chk("t3_len", 32'(acc_log.size()), 32'd9);
        for (int i = 0; i < 9 && i < acc_log.size(); i++) chk("t3_byte", 32'(acc_log[i]), 32'(exp3[i]));

        // Overflow: seven strobes with a stalled sink.
        acc_log.delete();
        for (int i = 1; i <= 7; i++) step(1'b1, mk(CT_MEM_WR, 32'(i), 32'h0, 3'd0), 1'b0);
        chk("t4_drops", 32'(out_drop_count), 32'd2);
        chk("t4_level", 32'(out_fifo_level), 32'd4);
        drain();
        chk("t4_len", 32'(acc_log.size()), 32'd25);
        if (acc_log.size() == 25) begin
            chk("t4_b0_r1", 32'(acc_log[0]), 32'h60);
            chk("t4_b0_r2", 32'(acc_log[5]), 32'h68);
            chk("t4_b0_r3", 32'(acc_log[10]), 32'h60);
            chk("t4_b0_r4", 32'(acc_log[15]), 32'h60);
            chk("t4_b0_r5", 32'(acc_log[20]), 32'h60);
            chk("t4_addr_r1", 32'(acc_log[4]), 32'h01);
            chk("t4_addr_r5", 32'(acc_log[24]), 32'h05);
        end

        // Two records back to back: twelve bytes without a gap.
        acc_log.delete();
        gap = 0;
        step(1'b1, r1, 1'b1);
        step(1'b1, mk(CT_MEM_RD, 32'h0badcafe, 32'h55, 3'd1), 1'b1);
        k = 0;
        while (acc_log.size() < 12 && k < 40) begin
            if (acc_log.size() > 0 && !out_valid) gap++;
            step(1'b0, idle_r, 1'b1);
            k++;
        end
        chk("t5_len", 32'(acc_log.size()), 32'd12);
        chk("t5_gap", 32'(gap), 32'd0);
        if (acc_log.size() == 12) chk("t5_b0_second", 32'(acc_log[6]), 32'h41);
        drain();

        // Asynchronous reset in the middle of a record.
        acc_log.delete();
        step(1'b1, r3, 1'b1);
        k = 0;
        while (acc_log.size() < 3 && k < 20) begin
            step(1'b0, idle_r, 1'b1);
            k++;
        end
        chk("t6_reached", 32'(acc_log.size()), 32'd3);
        chk_en = 1'b0;
        #2;
        lpc_reset = 1'b0;
        #1;
        chk("t6_async_valid", 32'(out_valid), 32'd0);
        model_reset();
        @(posedge clk); #1;
        lpc_reset = 1'b1;
        chk("t6_level", 32'(out_fifo_level), 32'd0);
        chk("t6_drops", 32'(out_drop_count), 32'd0);
        chk_en = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b0, idle_r, 1'b1);

        // Drop counter saturation.
        for (int i = 0; i < 262; i++) step(1'b1, mk(CT_IO_WR, 32'(i), 32'(i), 3'(i)), 1'b0);
        chk("sat_drops", 32'(out_drop_count), 32'(SAT));
        chk("sat_level", 32'(out_fifo_level), 32'd4);
        drain();

        // Randomised traffic with varying sink pressure.
        rdy_bias = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) rdy_bias = $urandom_range(0, 1) == 1;
            rr = mk(4'($urandom), $urandom, $urandom, 3'($urandom_range(0, 7)));
            step($urandom_range(0, 99) < 40, rr,
                 rdy_bias ? ($urandom_range(0, 99) < 85) : ($urandom_range(0, 99) < 25));
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
